// File: rtl/ef_pwm_capture_apb_if.sv
// APB bus bundle shared by the PWM capture block and its bus master.
interface ef_pwm_capture_apb_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/ef_pwm_capture_apb.sv
// PWM input capture: measures period and high time of pwm_in in prescaled
// PCLK ticks and reports them through a zero-wait-state APB register file.
module ef_pwm_capture_apb #(
    parameter int CNT_W = 32,
    parameter int DIV_W = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    ef_pwm_capture_apb_if.slave   apb,
    input  logic                  pwm_in,
    output logic                  irq
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HIGH = 2'd1, ST_LOW = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [DIV_W-1:0]   pc_q, pc_d, clkdiv_q, clkdiv_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d, high_q, high_d, hi_cap_q, hi_cap_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               valid_q, valid_d, ovf_q, ovf_d, irq_q, irq_d;

    logic               lvl, rise, fall, tick, en, ovf_hit;
    logic               load_hi, load_per, set_ovf;
    logic               wr_en, wr_status;
    logic [2:0]         idx;
    logic [CNT_W-1:0]   meas_val;
    logic [31:0]        prdata;
    logic               unused_bits;

    assign en       = ctrl_q[0];
    assign lvl      = sync2_q ^ ctrl_q[1];
    assign rise     = lvl & ~prev_q;
    assign fall     = ~lvl & prev_q;
    assign tick     = (pc_q == clkdiv_q);
    assign meas_val = cnt_q + CNT_W'(tick);
    assign ovf_hit  = (state_q != ST_IDLE) && (&cnt_q) && tick;

    assign idx       = apb.PADDR[4:2];
    assign wr_en     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign wr_status = wr_en && (idx == 3'd4);
    assign unused_bits = ^{apb.PADDR, apb.PWDATA};

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            pc_q     <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            hi_cap_q <= '0;
            clkdiv_q <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            hi_cap_q <= hi_cap_d;
            clkdiv_q <= clkdiv_d;
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    // Overflow outranks any edge seen in the same cycle.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (rise) state_d = ST_HIGH;
                ST_HIGH: if (ovf_hit) state_d = ST_IDLE; else if (fall) state_d = ST_LOW;
                ST_LOW:  if (ovf_hit) state_d = ST_IDLE; else if (rise) state_d = ST_HIGH;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        load_hi  = en && (state_q == ST_HIGH) && !ovf_hit && fall;
        load_per = en && (state_q == ST_LOW)  && !ovf_hit && rise;
        set_ovf  = en && ovf_hit;
    end

    // prev tracks the conditioned level even while disabled, so enabling never sees a stale edge.
    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        prev_d  = lvl;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (!en || rise || set_ovf) begin
            pc_d  = '0;
            cnt_d = '0;
        end else if (tick) begin
            pc_d  = '0;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            pc_d  = pc_q + DIV_W'(1);
        end
    end

    always_comb begin
        hi_cap_d = load_hi  ? meas_val : hi_cap_q;
        period_d = load_per ? meas_val : period_q;
        high_d   = load_per ? hi_cap_q : high_q;
        clkdiv_d = (wr_en && idx == 3'd2) ? apb.PWDATA[DIV_W-1:0] : clkdiv_q;
        ctrl_d   = (wr_en && idx == 3'd3) ? apb.PWDATA[2:0] : ctrl_q;
        valid_d  = load_per | (valid_q & ~(wr_status & apb.PWDATA[0]));
        ovf_d    = set_ovf  | (ovf_q   & ~(wr_status & apb.PWDATA[1]));
        irq_d    = ctrl_d[2] & (valid_d | ovf_d);
    end

    always_comb begin
        prdata = '0;
        if (apb.PSEL) begin
            case (idx)
                3'd0:    prdata = 32'(period_q);
                3'd1:    prdata = 32'(high_q);
                3'd2:    prdata = 32'(clkdiv_q);
                3'd3:    prdata = 32'(ctrl_q);
                3'd4:    prdata = {29'd0, lvl, ovf_q, valid_q};
                default: prdata = '0;
            endcase
        end
    end

    assign apb.PRDATA = prdata;
    assign apb.PREADY = 1'b1;
    assign irq        = irq_q;

endmodule

// File: tb/tb_ef_pwm_capture_apb.sv
// Directed bench for ef_pwm_capture_apb: table of waveforms plus hand-built corner sequences.
module tb_ef_pwm_capture_apb;

    localparam logic [31:0] A_PERIOD = 32'h00, A_HIGH = 32'h04, A_DIV = 32'h08;
    localparam logic [31:0] A_CTRL = 32'h0C, A_STAT = 32'h10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic pwm_in = 1'b0;
    logic irq;
    int   n_tests = 0;
    int   n_fail = 0;

    ef_pwm_capture_apb_if apb_if ();

    ef_pwm_capture_apb #(.CNT_W(8), .DIV_W(16)) dut (
        .PCLK    (clk),
        .PRESETn (rstn),
        .apb     (apb_if),
        .pwm_in  (pwm_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] div;
        int          hi;
        int          lo;
        logic [31:0] per;
        logic [31:0] high;
    } vec_t;

    vec_t vecs [5];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        apb_if.PADDR   = a;
        apb_if.PWDATA  = d;
        apb_if.PWRITE  = 1'b1;
        apb_if.PSEL    = 1'b1;
        apb_if.PENABLE = 1'b0;
        cyc(1);
        apb_if.PENABLE = 1'b1;
        cyc(1);
        apb_if.PSEL    = 1'b0;
        apb_if.PENABLE = 1'b0;
        apb_if.PWRITE  = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_if.PADDR  = a;
        apb_if.PWRITE = 1'b0;
        apb_if.PSEL   = 1'b1;
        #1;
        d = apb_if.PRDATA;
        apb_if.PSEL = 1'b0;
        check(name, d, exp);
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm_in = 1'b1;
        cyc(hi);
        pwm_in = 1'b0;
        cyc(lo);
    endtask

    initial begin
        vecs[0] = '{div: 16'd0, hi: 6,  lo: 7,  per: 32'd13, high: 32'd6};
        vecs[1] = '{div: 16'd1, hi: 12, lo: 14, per: 32'd13, high: 32'd6};
        vecs[2] = '{div: 16'd2, hi: 7,  lo: 6,  per: 32'd4,  high: 32'd2};
        vecs[3] = '{div: 16'd0, hi: 3,  lo: 10, per: 32'd13, high: 32'd3};
        vecs[4] = '{div: 16'd3, hi: 20, lo: 12, per: 32'd8,  high: 32'd5};

        apb_if.PADDR = '0; apb_if.PWDATA = '0; apb_if.PWRITE = 1'b0;
        apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
        cyc(3);
        rstn = 1'b1;
        cyc(1);

        // Reset state and basic register access
        chk_reg("rst_period", A_PERIOD, 0);
        chk_reg("rst_high",   A_HIGH,   0);
        chk_reg("rst_div",    A_DIV,    0);
        chk_reg("rst_ctrl",   A_CTRL,   0);
        chk_reg("rst_status", A_STAT,   0);
        check("rst_irq", {31'd0, irq}, 0);
        check("pready", {31'd0, apb_if.PREADY}, 1);
        apb_write(A_DIV, 32'h1234_ABCD);
        chk_reg("div_rw", A_DIV, 32'h0000_ABCD);
        apb_if.PADDR = A_DIV;
        #1;
        check("prdata_unsel", apb_if.PRDATA, 0);
        apb_write(32'h1C, 32'hFFFF_FFFF);
        chk_reg("unmapped_rd", 32'h14, 0);
        chk_reg("unmapped_wr_ctrl", A_CTRL, 0);

        for (int i = 0; i < 5; i++) begin
            apb_write(A_CTRL, 0);
            pwm_in = 1'b0;
            cyc(5);
            apb_write(A_DIV, {16'd0, vecs[i].div});
            apb_write(A_STAT, 3);
            apb_write(A_CTRL, 1);
            repeat (3) pulse(vecs[i].hi, vecs[i].lo);
            pwm_in = 1'b1;
            cyc(4);
            chk_reg($sformatf("v%0d_period", i), A_PERIOD, vecs[i].per);
            chk_reg($sformatf("v%0d_high", i),   A_HIGH,   vecs[i].high);
            chk_reg($sformatf("v%0d_status", i), A_STAT,   32'h5);
        end

        // Interrupt and W1C collision with a capture
        apb_write(A_CTRL, 5);
        check("irq_set", {31'd0, irq}, 1);
        pwm_in = 1'b0;
        cyc(1);
        apb_write(A_STAT, 1);
        check("irq_clr_low", {31'd0, irq}, 0);
        cyc(4);
        pwm_in = 1'b1;
        cyc(1);
        apb_write(A_STAT, 1);
        chk_reg("w1c_collide", A_STAT, 32'h5);
        check("irq_collide", {31'd0, irq}, 1);
        cyc(2);
        apb_write(A_STAT, 1);
        check("irq_w1c", {31'd0, irq}, 0);
        chk_reg("w1c_status", A_STAT, 32'h4);

        // Counter overflow with an 8-bit counter
        apb_write(A_DIV, 0);
        pwm_in = 1'b0;
        cyc(8);
        pulse(5, 6);
        pulse(5, 6);
        pwm_in = 1'b1;
        cyc(4);
        chk_reg("pre_ovf_period", A_PERIOD, 11);
        chk_reg("pre_ovf_high",   A_HIGH,   5);
        apb_write(A_STAT, 3);
        cyc(300);
        chk_reg("ovf_status", A_STAT,   32'h6);
        chk_reg("ovf_period", A_PERIOD, 11);
        chk_reg("ovf_high",   A_HIGH,   5);
        check("ovf_irq", {31'd0, irq}, 1);
        apb_write(A_STAT, 3);
        pwm_in = 1'b0;
        cyc(7);
        pwm_in = 1'b1;
        cyc(4);
        chk_reg("ovf_idle_rise", A_STAT, 32'h4);
        cyc(2);
        pwm_in = 1'b0;
        cyc(7);
        pwm_in = 1'b1;
        cyc(4);
        chk_reg("post_ovf_period", A_PERIOD, 13);
        chk_reg("post_ovf_high",   A_HIGH,   6);

        // EN dropped mid-HIGH, re-enabled while input still high
        apb_write(A_CTRL, 4);
        apb_write(A_STAT, 3);
        pwm_in = 1'b0;
        cyc(5);
        apb_write(A_CTRL, 5);
        pwm_in = 1'b1;
        cyc(4);
        apb_write(A_CTRL, 4);
        apb_write(A_CTRL, 5);
        cyc(4);
        pwm_in = 1'b0;
        cyc(9);
        pwm_in = 1'b1;
        cyc(4);
        chk_reg("abort_no_cap", A_STAT, 32'h4);
        check("abort_irq", {31'd0, irq}, 0);
        cyc(2);
        pwm_in = 1'b0;
        cyc(7);
        pwm_in = 1'b1;
        cyc(4);
        chk_reg("abort_period", A_PERIOD, 13);
        chk_reg("abort_high",   A_HIGH,   6);
        chk_reg("abort_status", A_STAT,   32'h5);

        // Inverted input, enabled while the conditioned level is already high
        apb_write(A_CTRL, 0);
        pwm_in = 1'b0;
        cyc(5);
        apb_write(A_CTRL, 2);
        cyc(4);
        apb_write(A_STAT, 3);
        chk_reg("inv_level", A_STAT, 32'h4);
        apb_write(A_CTRL, 3);
        cyc(3);
        pwm_in = 1'b1;
        cyc(9);
        pwm_in = 1'b0;
        cyc(4);
        chk_reg("inv_first_rise", A_STAT, 32'h4);
        pwm_in = 1'b1;
        cyc(9);
        pwm_in = 1'b0;
        cyc(4);
        chk_reg("inv_period", A_PERIOD, 13);
        chk_reg("inv_high",   A_HIGH,   4);

        // Reset in the middle of a measurement
        apb_write(A_CTRL, 7);
        check("pre_rst_irq", {31'd0, irq}, 1);
        cyc(3);
        rstn = 1'b0;
        cyc(1);
        rstn = 1'b1;
        chk_reg("mid_rst_period", A_PERIOD, 0);
        chk_reg("mid_rst_high",   A_HIGH,   0);
        chk_reg("mid_rst_div",    A_DIV,    0);
        chk_reg("mid_rst_ctrl",   A_CTRL,   0);
        chk_reg("mid_rst_status", A_STAT,   0);
        check("mid_rst_irq", {31'd0, irq}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ef_pwm_capture_apb.md
Name: ef_pwm_capture_apb

Overview:
- APB-responder PWM input-capture block: the decoding counterpart of the PWM32 generator.
- Measures the period and high time of an external PWM waveform, for example a loop-back of pwmA, in prescaled clock ticks.
- Exposes the results, a status flag and an interrupt through an APB register file.
- Sits on the same APB segment as the PWM32 generator.

Parameters:
- CNT_W, 32: width of the tick counter and of the PERIOD/HIGH registers (at most 32).
- DIV_W, 16: width of the CLKDIV prescaler register.

Ports:
- PCLK  in  1  sole clock.
- PRESETn  in  1  reset, synchronous, active-low.
- PADDR  in  32  APB address; bits [4:2] decoded.
- PWRITE  in  1  APB write.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready, tied to 1.
- pwm_in  in  1  asynchronous PWM input.
- irq  out  1  interrupt, level.

Behaviour:
- Interface: one clock, PCLK; reset PRESETn is synchronous and active-low.
- Reset clears all registers and state to 0; state returns to IDLE; irq=0; PRDATA=0 when unselected.
- APB protocol:
  - Zero wait states; PREADY=1 always.
  - A write commits on the cycle where PSEL & PENABLE & PWRITE are all high.
  - PRDATA is combinational from PADDR while PSEL is high; otherwise 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map:
  - 0x00 PERIOD: RO, zero-extended CNT_W.
  - 0x04 HIGH: RO.
  - 0x08 CLKDIV: RW, DIV_W bits.
  - 0x0C CONTROL: RW; bit0 EN, bit1 INV (invert input), bit2 IE.
  - 0x10 STATUS: bit0 VALID (W1C), bit1 OVF (W1C), bit2 LEVEL (RO, conditioned input).
- Input conditioning:
  - Two-flop synchronizer, then XOR with INV, then a prev-level register.
  - rise = lvl & ~prev; fall = ~lvl & prev.
  - Total pin-to-edge latency is 3 PCLK; it is constant, so measurements are unaffected.
  - prev updates every cycle regardless of EN, so enabling never produces a false edge.
- Prescaler/counter (pc: DIV_W bits; cnt: CNT_W bits):
  - tick = (pc == CLKDIV).
  - On a rise cycle: pc<=0 and cnt<=0.
  - Otherwise, if tick: pc<=0 and cnt<=cnt+1; else pc<=pc+1.
  - Captured value is cnt+tick evaluated in the edge cycle.
  - Result: value = floor(cycles / (CLKDIV+1)). With CLKDIV=0 the value is the exact cycle count.
- FSM:
  - IDLE: waits for rise, then goes to HIGH. A fall in IDLE is ignored. Enabling while the input is already high waits for the next rise, so no partial pulse is captured.
  - HIGH: on fall, hi_cap<=cnt+tick and go to LOW.
  - LOW: on rise, PERIOD<=cnt+tick, HIGH<=hi_cap, VALID<=1, and go to HIGH (counter restarts; measurement is continuous).
  - Rise while in HIGH cannot occur, because edges alternate.
- Overflow:
  - Applies in HIGH or LOW when cnt is all ones and tick is high.
  - OVF<=1, go to IDLE, cnt<=0.
  - PERIOD and HIGH hold their previous values.
- EN=0 (including mid-measurement): next cycle state=IDLE, cnt=0, pc=0; PERIOD/HIGH/STATUS hold.
- W1C collision: a hardware set and a software clear of the same bit in the same cycle; set wins.
- PERIOD/HIGH update atomically in the same cycle, so a read always returns a coherent pair.
- irq = IE & (VALID | OVF), registered; it deasserts the cycle after the W1C write.
- A CLKDIV write mid-measurement takes effect immediately; if pc > the new CLKDIV, pc wraps through its maximum value. This is accepted and not flagged.

Test Plan:
- CLKDIV=0, EN=1; pwm_in high 6 / low 7 cycles, repeating -> after the second rise: PERIOD=13, HIGH=6, VALID=1; values stay stable on later periods.
- CLKDIV=1, same waveform scaled to high 12 / low 14 -> PERIOD=13, HIGH=6. CLKDIV=2 with high 7 / low 6 -> PERIOD=4, HIGH=2 (floor).
- INV=1, input low 4 / high 9 -> HIGH=4, PERIOD=13. Enable asserted while input is high -> first capture only after a full rise-to-rise period.
- IE=1; capture sets VALID -> irq=1 one cycle later. Write STATUS=0x1 on the capture cycle -> VALID stays 1. A later W1C -> irq=0 the next cycle.
- CNT_W=8, CLKDIV=0, input held high 300 cycles after a rise -> OVF=1, state IDLE, PERIOD/HIGH unchanged. A following normal 6/7 waveform -> PERIOD=13.
- EN cleared mid-HIGH, then re-set -> no capture from the aborted pulse. PRESETn=0 for one cycle mid-measurement -> all registers read 0 and irq=0.
